rc4_decrypt_core: RTL and testbench

- Consumer side of the key-scheduling shuffle. After the shuffle phase completes, this block runs the RC4 keystream generator (PRGA) over the shuffled S array in the 256x8 S RAM.
- Each keystream byte is XORed with the encrypted message ROM, and the result is written to the decrypted-message RAM.
- Started and stopped by the top-level controller through a start/done handshake, in the same style as the shuffle stage.

---
 rtl/rc4_decrypt_core.sv | 172 +++++++++++++++++
 tb/tb_rc4_decrypt_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_core.sv
// RC4 keystream generator (PRGA) over a shuffled 256x8 S RAM; XORs each keystream byte with the
// encrypted ROM and writes the plaintext RAM. Optional plaintext range check: RC4_VALID_CHECK_EN.
module rc4_decrypt_core #(
   parameter int unsigned MSG_LEN = 32,
   parameter int unsigned MADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic               done,
   output logic [7:0]         s_addr,
   output logic [7:0]         s_wdata,
   output logic               s_wren,
   input  logic [7:0]         s_rdata,
   output logic [MADDR_W-1:0] enc_addr,
   input  logic [7:0]         enc_rdata,
   output logic [MADDR_W-1:0] dec_addr,
   output logic [7:0]         dec_wdata,
   output logic               dec_wren,
   output logic               key_invalid
);

   localparam logic [MADDR_W-1:0] LAST_K = MADDR_W'(MSG_LEN - 1);
`ifdef RC4_VALID_CHECK_EN
   localparam bit VALID_CHECK = 1'b1;
`else
   localparam bit VALID_CHECK = 1'b0;
`endif

   typedef enum logic [3:0] {
      IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, RD_F, WAIT_F, WR_D, DONE
   } state_t;

   state_t             state, state_d;
   logic [7:0]         i, i_d, j, j_d, si, si_d, sj, sj_d;
   logic [MADDR_W-1:0] k, k_d;
   logic [7:0]         s_addr_d, s_wdata_d, dec_wdata_d;
   logic               s_wren_d, dec_wren_d, done_d, key_invalid_d;
   logic [MADDR_W-1:0] enc_addr_d, dec_addr_d;
   logic               plain_ok_c;
   logic               reject_c;

   // dec_wdata holds f^e while in WR_D, so the range check looks at the register
   assign plain_ok_c = ((dec_wdata >= 8'h61) && (dec_wdata <= 8'h7A)) || (dec_wdata == 8'h20);
   assign reject_c   = VALID_CHECK && !plain_ok_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         i           <= '0;
         j           <= '0;
         k           <= '0;
         si          <= '0;
         sj          <= '0;
         s_addr      <= '0;
         s_wdata     <= '0;
         s_wren      <= 1'b0;
         enc_addr    <= '0;
         dec_addr    <= '0;
         dec_wdata   <= '0;
         dec_wren    <= 1'b0;
         done        <= 1'b0;
         key_invalid <= 1'b0;
      end else begin
         state       <= state_d;
         i           <= i_d;
         j           <= j_d;
         k           <= k_d;
         si          <= si_d;
         sj          <= sj_d;
         s_addr      <= s_addr_d;
         s_wdata     <= s_wdata_d;
         s_wren      <= s_wren_d;
         enc_addr    <= enc_addr_d;
         dec_addr    <= dec_addr_d;
         dec_wdata   <= dec_wdata_d;
         dec_wren    <= dec_wren_d;
         done        <= done_d;
         key_invalid <= key_invalid_d;
      end
   end

   // Next state and working registers, then outputs decoded from the state being entered
   always_comb begin
      state_d       = state;
      i_d           = i;
      j_d           = j;
      k_d           = k;
      si_d          = si;
      sj_d          = sj;
      key_invalid_d = key_invalid;
      s_addr_d      = '0;
      s_wdata_d     = '0;
      s_wren_d      = 1'b0;
      enc_addr_d    = '0;
      dec_addr_d    = '0;
      dec_wdata_d   = '0;
      dec_wren_d    = 1'b0;
      done_d        = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               i_d           = '0;
               j_d           = '0;
               k_d           = '0;
               key_invalid_d = 1'b0;
               state_d       = RD_I;
            end
         end
         RD_I: begin
            i_d     = i + 8'd1;
            state_d = WAIT_I;
         end
         WAIT_I: begin
            si_d    = s_rdata;
            j_d     = j + s_rdata;
            state_d = RD_J;
         end
         RD_J:   state_d = WAIT_J;
         WAIT_J: begin
            sj_d    = s_rdata;
            state_d = WR_I;
         end
         WR_I:   state_d = WR_J;
         WR_J:   state_d = RD_F;
         RD_F:   state_d = WAIT_F;
         WAIT_F: state_d = WR_D;
         WR_D: begin
            key_invalid_d = key_invalid | reject_c;
            if ((k == LAST_K) || reject_c) begin
               state_d = DONE;
            end else begin
               k_d     = k + MADDR_W'(1);
               state_d = RD_I;
            end
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      unique case (state_d)
         RD_I: s_addr_d = i_d + 8'd1;
         RD_J: s_addr_d = j_d;
         WR_I: begin
            s_addr_d  = i_d;
            s_wdata_d = sj_d;
            s_wren_d  = 1'b1;
         end
         WR_J: begin
            s_addr_d  = j_d;
            s_wdata_d = si_d;
            s_wren_d  = 1'b1;
         end
         RD_F: begin
            s_addr_d   = si_d + sj_d;
            enc_addr_d = k_d;
         end
         // only reached from WAIT_F, where keystream and cipher bytes are both valid
         WR_D: begin
            dec_addr_d  = k_d;
            dec_wdata_d = s_rdata ^ enc_rdata;
            dec_wren_d  = 1'b1;
         end
         DONE: done_d = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Directed bench for rc4_decrypt_core: bench-owned S RAM, cipher ROM and plaintext RAM plus a
// software RC4 model. Define RC4_VALID_CHECK_EN to exercise the plaintext range check instead.
module tb_rc4_decrypt_core;

   localparam int unsigned MSG_LEN = 32;
   localparam int unsigned MADDR_W = 5;
   localparam int unsigned FULL_CYC = 1 + 9 * MSG_LEN;

   logic clk = 1'b0;
   logic reset_n;
   logic start;
   logic done, s_wren, dec_wren, key_invalid;
   logic [7:0] s_addr, s_wdata, s_rdata, enc_rdata, dec_wdata;
   logic [MADDR_W-1:0] enc_addr, dec_addr;

   logic [7:0] s_mem   [256];
   logic [7:0] s_init  [256];
   logic [7:0] snap    [256];
   logic [7:0] m_s     [256];
   logic [7:0] enc_mem [MSG_LEN];
   logic [7:0] dec_mem [MSG_LEN];
   logic [7:0] m_dec   [MSG_LEN];
   logic       load, cnt_clr;
   int         sw_cnt, dw_cnt;
   int         n_chk = 0, n_pass = 0;

   rc4_decrypt_core #(.MSG_LEN(MSG_LEN), .MADDR_W(MADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .done(done),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
      .enc_addr(enc_addr), .enc_rdata(enc_rdata),
      .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
      .key_invalid(key_invalid)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories, write-pulse counters and an S snapshot taken at byte 2
   always @(posedge clk) begin
      if (load) begin
         for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
         for (int n = 0; n < MSG_LEN; n++) dec_mem[n] <= 8'hEE;
      end else begin
         if (s_wren) s_mem[s_addr] <= s_wdata;
         if (dec_wren) dec_mem[dec_addr] <= dec_wdata;
      end
      s_rdata   <= s_mem[s_addr];
      enc_rdata <= enc_mem[enc_addr];
      if (cnt_clr) begin
         sw_cnt <= 0;
         dw_cnt <= 0;
      end else begin
         if (s_wren) sw_cnt <= sw_cnt + 1;
         if (dec_wren) dw_cnt <= dw_cnt + 1;
      end
      if (dec_wren && dec_addr == 5'd2) snap <= s_mem;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_run(input int n);
      logic [7:0] mi, mj, t;
      m_s = s_init;
      mi = 8'd0;
      mj = 8'd0;
      for (int b = 0; b < n; b++) begin
         mi = mi + 8'd1;
         mj = mj + m_s[mi];
         t = m_s[mi];
         m_s[mi] = m_s[mj];
         m_s[mj] = t;
         t = m_s[mi] + m_s[mj];
         m_dec[b] = m_s[t] ^ enc_mem[b];
      end
   endtask

   // Called at a negedge with start low: load S from s_init, clear plaintext RAM and counters
   task automatic prep();
      load = 1'b1;
      cnt_clr = 1'b1;
      @(negedge clk);
      load = 1'b0;
      cnt_clr = 1'b0;
   endtask

   // Called at a negedge: raise start and count edges until done is seen
   task automatic do_run(input string tag, input int exp_cyc, input int exp_sw, input int exp_dw);
      int cnt = 0;
      start = 1'b1;
      while (cnt < 1000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 1) check({tag, "_first_i_addr"}, 32'(s_addr), 32'd1);
         if (cnt == 3) check({tag, "_first_j_addr"}, 32'(s_addr), 32'(s_init[1]));
         if (done) break;
      end
      check({tag, "_latency"}, 32'(cnt), 32'(exp_cyc));
      check({tag, "_s_wren_pulses"}, 32'(sw_cnt), 32'(exp_sw));
      check({tag, "_dec_wren_pulses"}, 32'(dw_cnt), 32'(exp_dw));
   endtask

   task automatic compare_model(input string tag);
      int errs = 0;
      for (int b = 0; b < MSG_LEN; b++)
         check($sformatf("%s_dec%0d", tag, b), 32'(dec_mem[b]), 32'(m_dec[b]));
      for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) errs++;
      check({tag, "_s_final_errs"}, 32'(errs), 32'd0);
   endtask

   task automatic drop_start();
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int sw0, dw0;
      reset_n = 1'b0;
      start   = 1'b0;
      load    = 1'b0;
      cnt_clr = 1'b1;
      for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
      for (int n = 0; n < MSG_LEN; n++) enc_mem[n] = 8'h00;
      #12;
      check("rst_addr_data", {s_addr, s_wdata, 3'b0, enc_addr, 3'b0, dec_addr}, 32'd0);
      check("rst_flags", {dec_wdata, s_wren, dec_wren, done, key_invalid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      prep();

`ifdef RC4_VALID_CHECK_EN
      enc_mem[0] = 8'h63;
      do_run("vchk", 1 + 9 * 2, 4, 2);
      check("vchk_dec0", 32'(dec_mem[0]), 32'h61);
      check("vchk_dec1", 32'(dec_mem[1]), 32'h05);
      check("vchk_dec2_untouched", 32'(dec_mem[2]), 32'hEE);
      check("vchk_key_invalid", 32'(key_invalid), 32'd1);
      drop_start();
      check("vchk_hold_invalid", 32'(key_invalid), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("vchk_clear_on_start", 32'(key_invalid), 32'd0);
      start = 1'b0;
`else
      // Identity S, zero cipher: plaintext equals the keystream
      model_run(MSG_LEN);
      do_run("ident", FULL_CYC, 2 * MSG_LEN, MSG_LEN);
      check("ident_dec0", 32'(dec_mem[0]), 32'h02);
      check("ident_dec1", 32'(dec_mem[1]), 32'h05);
      check("ident_dec2", 32'(dec_mem[2]), 32'h07);
      check("ident_snap_s1", 32'(snap[1]), 32'h01);
      check("ident_snap_s2", 32'(snap[2]), 32'h03);
      check("ident_snap_s3", 32'(snap[3]), 32'h05);
      check("ident_snap_s5", 32'(snap[5]), 32'h02);
      check("ident_key_invalid", 32'(key_invalid), 32'd0);
      compare_model("ident");

      // start held high through DONE must not restart
      sw0 = sw_cnt;
      dw0 = dw_cnt;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold_done_c%0d", c), 32'(done), 32'd1);
      end
      check("hold_no_writes", 32'((sw_cnt - sw0) + (dw_cnt - dw0)), 32'd0);

      // One low cycle on start (S reloaded meanwhile), then a fresh run with s[1]=0
      s_init[0] = 8'h01;
      s_init[1] = 8'h00;
      for (int n = 0; n < MSG_LEN; n++) enc_mem[n] = 8'($urandom_range(0, 255));
      model_run(MSG_LEN);
      @(negedge clk);
      start   = 1'b0;
      load    = 1'b1;
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      check("drop_done_low", 32'(done), 32'd0);
      @(negedge clk);
      load    = 1'b0;
      cnt_clr = 1'b0;
      do_run("s1zero", FULL_CYC, 2 * MSG_LEN, MSG_LEN);
      check("s1zero_dec0_hand", 32'(dec_mem[0]), 32'(enc_mem[0] ^ 8'h01));
      compare_model("s1zero");
      drop_start();

      // Reset in the middle of a run, then a complete pass from a reloaded S
      for (int n = 0; n < 256; n++) s_init[n] = 8'(n * 37 + 11);
      for (int n = 0; n < MSG_LEN; n++) enc_mem[n] = 8'($urandom_range(0, 255));
      model_run(MSG_LEN);
      prep();
      start = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_addr_data", {s_addr, s_wdata, 3'b0, enc_addr, 3'b0, dec_addr}, 32'd0);
      check("midrst_flags", {dec_wdata, s_wren, dec_wren, done, key_invalid}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      prep();
      do_run("afterrst", FULL_CYC, 2 * MSG_LEN, MSG_LEN);
      compare_model("afterrst");
      drop_start();
      check("afterrst_idle_done", 32'(done), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
